// File: rtl/npuarc_to_txn_tracker.sv
// -----------------------------------------------------------------------------
// npuarc_to_txn_tracker
//
// Purpose:
//   Tracks outstanding bus transactions (request accepted / ack retired) and
//   drives a timeout monitor's to_start/to_end levels so that the monitor
//   counts only while work is outstanding and restarts on every retire
//   (forward-progress watchdog). The monitor's to_flag is turned into a
//   sticky error, a one-cycle interrupt pulse and, optionally, an abort flush
//   that synthesises retires until nothing is outstanding.
//
// Configuration macro:
//   NPUARC_TO_ABORT_EN - when defined, a timeout is followed by an ABORT
//                        state that emits abort_ack once per cycle until the
//                        outstanding count reaches zero. When undefined there
//                        is no ABORT state and abort_ack is tied low.
//
// Parameters:
//   OST_W   - width of the outstanding-transaction counter
//   OST_MAX - outstanding count at which req_ready drops (1..2**OST_W-1)
//
// Ports:
//   clk        in   clock, single domain
//   rst_a      in   synchronous active-high reset
//   req_valid  in   new transaction request
//   req_ready  out  request accepted when req_valid & req_ready
//   ack        in   one transaction retired
//   to_flag    in   timeout status from the monitor (level)
//   err_clr    in   clear the sticky error
//   to_start   out  to monitor: level, rising edge arms its counter
//   to_end     out  to monitor: level, rising edge clears its counter
//   to_err     out  sticky timeout error
//   to_irq     out  one-cycle pulse on to_err 0->1
//   ost_cnt    out  current outstanding count
//   abort_ack  out  synthetic error retire (abort build only)
// -----------------------------------------------------------------------------
module npuarc_to_txn_tracker #(
    parameter int OST_W   = 4,
    parameter int OST_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             ack,
    input  logic             to_flag,
    input  logic             err_clr,
    output logic             to_start,
    output logic             to_end,
    output logic             to_err,
    output logic             to_irq,
    output logic [OST_W-1:0] ost_cnt,
    output logic             abort_ack
);

    localparam logic [OST_W-1:0] OST_MAX_C = OST_MAX[OST_W-1:0];
    localparam logic [OST_W-1:0] ONE_C     = {{(OST_W-1){1'b0}}, 1'b1};
    localparam logic [OST_W-1:0] ZERO_C    = {OST_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RESTART = 3'd2,
`ifdef NPUARC_TO_ABORT_EN
        ST_TIMEOUT = 3'd3,
        ST_ABORT   = 3'd4
`else
        ST_TIMEOUT = 3'd3
`endif
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [OST_W-1:0] ost_cnt_r;
    logic [OST_W-1:0] next_cnt_s;
    logic             req_ready_r;
    logic             to_start_r;
    logic             to_end_r;
    logic             to_err_r;
    logic             to_irq_r;
    logic             abort_ack_r;
    logic             acc_s;
    logic             ret_s;
    logic             err_set_s;
    logic             run_s;
    logic             ready_s;
    logic             abort_nxt_s;

`ifdef NPUARC_TO_ABORT_EN
    logic [OST_W:0]   cnt_ext_s;
    logic [OST_W:0]   dec_s;
    logic [OST_W:0]   diff_s;
`endif

    // Accept/retire qualification; an ack with nothing outstanding is spurious.
    always_comb begin
        acc_s = req_valid & req_ready_r;
        ret_s = ack & (ost_cnt_r != ZERO_C);
    end

    // Next outstanding count; never wraps in either direction.
    always_comb begin
        next_cnt_s = ost_cnt_r;
`ifdef NPUARC_TO_ABORT_EN
        // ABORT retires one synthetic transaction per cycle plus any real ack.
        cnt_ext_s = {1'b0, ost_cnt_r};
        dec_s     = {{(OST_W-1){1'b0}}, ret_s, ~ret_s};
        diff_s    = cnt_ext_s - dec_s;
        if (state_r == ST_ABORT) begin
            if (cnt_ext_s <= dec_s) begin
                next_cnt_s = ZERO_C;
            end else begin
                next_cnt_s = diff_s[OST_W-1:0];
            end
        end else begin
`endif
            case ({acc_s, ret_s})
                2'b10:   next_cnt_s = ost_cnt_r + ONE_C;
                2'b01:   next_cnt_s = ost_cnt_r - ONE_C;
                default: next_cnt_s = ost_cnt_r;
            endcase
`ifdef NPUARC_TO_ABORT_EN
        end
`endif
    end

    // Next-state logic, evaluated on the next count; an empty count always wins.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (next_cnt_s != ZERO_C) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (next_cnt_s == ZERO_C) begin
                    next_state_s = ST_IDLE;
                end else if (ret_s) begin
                    next_state_s = ST_RESTART;
                end else if (to_flag) begin
                    next_state_s = ST_TIMEOUT;
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_RESTART: begin
                // Single-cycle to_end pulse, then re-arm if work remains.
                if (next_cnt_s != ZERO_C) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_TIMEOUT: begin
                if (next_cnt_s == ZERO_C) begin
                    next_state_s = ST_IDLE;
`ifdef NPUARC_TO_ABORT_EN
                end else begin
                    next_state_s = ST_ABORT;
                end
`else
                end else if (ret_s) begin
                    next_state_s = ST_RESTART;
                end else begin
                    next_state_s = ST_TIMEOUT;
                end
`endif
            end
`ifdef NPUARC_TO_ABORT_EN
            ST_ABORT: begin
                if (next_cnt_s == ZERO_C) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ABORT;
                end
            end
`endif
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state/count.
    always_comb begin
        run_s     = (next_state_s == ST_ARMED) || (next_state_s == ST_TIMEOUT);
        err_set_s = (next_state_s == ST_TIMEOUT) && (state_r != ST_TIMEOUT);
`ifdef NPUARC_TO_ABORT_EN
        abort_nxt_s = (next_state_s == ST_ABORT);
`else
        abort_nxt_s = 1'b0;
`endif
        ready_s = (next_cnt_s < OST_MAX_C) && !abort_nxt_s;
    end

    // State, count and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_r     <= ST_IDLE;
            ost_cnt_r   <= ZERO_C;
            req_ready_r <= 1'b1;
            to_start_r  <= 1'b0;
            to_end_r    <= 1'b1;
            to_err_r    <= 1'b0;
            to_irq_r    <= 1'b0;
            abort_ack_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            ost_cnt_r   <= next_cnt_s;
            req_ready_r <= ready_s;
            to_start_r  <= run_s;
            to_end_r    <= ~run_s;
            // A set in the same cycle as a clear keeps the error.
            if (err_set_s) begin
                to_err_r <= 1'b1;
            end else if (err_clr) begin
                to_err_r <= 1'b0;
            end else begin
                to_err_r <= to_err_r;
            end
            to_irq_r    <= err_set_s & ~to_err_r;
            abort_ack_r <= abort_nxt_s;
        end
    end

    assign req_ready = req_ready_r;
    assign to_start  = to_start_r;
    assign to_end    = to_end_r;
    assign to_err    = to_err_r;
    assign to_irq    = to_irq_r;
    assign ost_cnt   = ost_cnt_r;
    assign abort_ack = abort_ack_r;

endmodule

// File: tb/tb_npuarc_to_txn_tracker.sv
// -----------------------------------------------------------------------------
// tb_npuarc_to_txn_tracker
//
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared every cycle against a behavioural model that tracks the
// outstanding count plus a few condition flags (restart pulse pending,
// timed out, aborting) rather than an explicit state machine.
// -----------------------------------------------------------------------------
module tb_npuarc_to_txn_tracker;

    localparam int OST_W   = 4;
    localparam int OST_MAX = 15;

    logic             clk;
    logic             rst_a;
    logic             req_valid;
    logic             req_ready;
    logic             ack;
    logic             to_flag;
    logic             err_clr;
    logic             to_start;
    logic             to_end;
    logic             to_err;
    logic             to_irq;
    logic [OST_W-1:0] ost_cnt;
    logic             abort_ack;

    npuarc_to_txn_tracker #(.OST_W(OST_W), .OST_MAX(OST_MAX)) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ack       (ack),
        .to_flag   (to_flag),
        .err_clr   (err_clr),
        .to_start  (to_start),
        .to_end    (to_end),
        .to_err    (to_err),
        .to_irq    (to_irq),
        .ost_cnt   (ost_cnt),
        .abort_ack (abort_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_cnt;
    bit m_restart;   // one-cycle counter-clear pulse in progress
    bit m_timeout;   // timed out, still counting
    bit m_abort;     // flushing outstanding work
    bit m_err;
    bit m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return (m_cnt < OST_MAX) && !m_abort;
    endfunction

    function automatic bit exp_start();
        return (m_cnt > 0) && !m_restart && !m_abort;
    endfunction

    task automatic set_in(input bit rv, input bit ak, input bit tf, input bit ec);
        req_valid = rv;
        ack       = ak;
        to_flag   = tf;
        err_clr   = ec;
    endtask

    task automatic compare_all();
        chk("ost_cnt",   32'(ost_cnt),   32'(m_cnt));
        chk("req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("to_start",  32'(to_start),  32'(exp_start()));
        chk("to_end",    32'(to_end),    32'(!exp_start()));
        chk("to_err",    32'(to_err),    32'(m_err));
        chk("to_irq",    32'(to_irq),    32'(m_irq));
        chk("abort_ack", 32'(abort_ack), 32'(m_abort));
    endtask

    // One clock: model consumes the inputs present at the edge, then outputs are compared.
    task automatic step();
        bit acc;
        bit ret;
        bit newly;
        int nc;
        @(posedge clk);
        if (rst_a) begin
            m_cnt = 0; m_restart = 0; m_timeout = 0; m_abort = 0; m_err = 0; m_irq = 0;
        end else begin
            acc   = req_valid && exp_ready();
            ret   = ack && (m_cnt > 0);
            newly = 0;
            if (m_abort) begin
                nc = m_cnt - 1 - int'(ret);
                if (nc < 0) nc = 0;
            end else begin
                nc = m_cnt + int'(acc) - int'(ret);
            end
            if (nc == 0) begin
                m_restart = 0; m_timeout = 0; m_abort = 0;
            end else if (m_abort) begin
                m_abort = 1;
            end else if (m_restart) begin
                m_restart = 0;
            end else if (m_cnt == 0) begin
                m_restart = 0;
            end else if (m_timeout) begin
`ifdef NPUARC_TO_ABORT_EN
                m_timeout = 0;
                m_abort   = 1;
`else
                if (ret) begin
                    m_timeout = 0;
                    m_restart = 1;
                end
`endif
            end else if (ret) begin
                m_restart = 1;
            end else if (to_flag) begin
                m_timeout = 1;
                newly     = 1;
            end
            m_irq = newly && !m_err;
            if (newly) m_err = 1;
            else if (err_clr) m_err = 0;
            m_cnt = nc;
        end
        #1;
        compare_all();
    endtask

    initial begin
        int p_req;
        int p_ack;
        rst_a = 1'b1;
        set_in(0, 0, 0, 0);
        m_cnt = 0; m_restart = 0; m_timeout = 0; m_abort = 0; m_err = 0; m_irq = 0;
        step();
        step();
        // Reset values against fixed constants
        chk("rst_ost_cnt",  32'(ost_cnt),  32'd0);
        chk("rst_to_end",   32'(to_end),   32'd1);
        chk("rst_to_start", 32'(to_start), 32'd0);
        chk("rst_ready",    32'(req_ready), 32'd1);
        rst_a = 1'b0;

        // Three back-to-back requests
        set_in(1, 0, 0, 0);
        step();
        chk("t1_start_after_first", 32'(to_start), 32'd1);
        step();
        step();
        set_in(0, 0, 0, 0);
        step();
        chk("t1_cnt3", 32'(ost_cnt), 32'd3);
        chk("t1_end0", 32'(to_end),  32'd0);

        // Ack -> restart pulse -> re-arm
        set_in(0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0);
        chk("t2_end_pulse", 32'(to_end), 32'd1);
        step();
        chk("t2_rearm", 32'(to_start), 32'd1);
        set_in(0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0);
        step();
        chk("t2_cnt1", 32'(ost_cnt), 32'd1);

        // Accept and retire together: count unchanged, restart seen
        set_in(1, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0);
        chk("t3_cnt_held", 32'(ost_cnt), 32'd1);
        chk("t3_restart",  32'(to_end),  32'd1);
        step();
        set_in(0, 1, 0, 0);
        step();
        step();   // spurious ack at zero
        set_in(0, 0, 0, 0);
        chk("t3_spurious", 32'(ost_cnt), 32'd0);
        step();

        // Fill to OST_MAX, stall, free one slot
        set_in(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) step();
        chk("t4_full_cnt",   32'(ost_cnt),   32'(OST_MAX));
        chk("t4_full_ready", 32'(req_ready), 32'd0);
        set_in(1, 1, 0, 0);
        step();
        set_in(1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0);
        chk("t4_refill", 32'(ost_cnt), 32'(OST_MAX));
        step();

        // Drain to 2, then time out
        set_in(0, 1, 0, 0);
        for (int i = 0; i < 13; i++) step();
        set_in(0, 0, 0, 0);
        step();
        step();
        chk("t5_cnt2", 32'(ost_cnt), 32'd2);
        set_in(0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0);
        chk("t5_err", 32'(to_err), 32'd1);
        chk("t5_irq", 32'(to_irq), 32'd1);
        step();
        chk("t5_irq_once", 32'(to_irq), 32'd0);
        for (int i = 0; i < 6; i++) step();
        // Re-timeout after a retire, with a clear in the same cycle
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        set_in(1, 0, 0, 0);
        step();
        step();
        set_in(0, 0, 1, 0);
        step();
        set_in(1, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0);
        step();
        set_in(0, 0, 1, 1);
        step();
        set_in(0, 0, 0, 0);
        chk("t5_set_wins", 32'(to_err), 32'd1);
        step();

        // Timeout at count 3: abort flush or hold
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        set_in(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        set_in(0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
`ifdef NPUARC_TO_ABORT_EN
        chk("t6_flushed", 32'(ost_cnt), 32'd0);
        chk("t6_idle_end", 32'(to_end), 32'd1);
`else
        chk("t6_held_cnt", 32'(ost_cnt), 32'd3);
        chk("t6_held_start", 32'(to_start), 32'd1);
`endif

        // Randomized traffic, alternating fill-biased and drain-biased segments
        for (int seg = 0; seg < 8; seg++) begin
            p_req = (seg % 2 == 1) ? 85 : 30;
            p_ack = (seg % 2 == 1) ? 25 : 70;
            for (int c = 0; c < 300; c++) begin
                rst_a = ($urandom_range(0, 199) == 0);
                set_in($urandom_range(0, 99) < p_req,
                       $urandom_range(0, 99) < p_ack,
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 19) == 0);
                step();
            end
        end
        rst_a = 1'b0;
        set_in(0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
